note_match_multilane: RTL and testbench
=======================================

// Module: note_match_multilane
// PURPOSE
//  Per-lane note matcher for all fret lanes in one block. Each lane keeps a past and a future note
//  slot, fetched from its note buffer by request/available handshake. Each press edge is paired
//  with the nearer valid slot, graded by timing error, and reported with its note time.
//  Notes that age out unmatched raise miss; presses with no note in the window raise stray.
//  Sits between the per-lane note FIFOs and the scoring block.
// PARAMETERS
//  LANES        5    number of independent lanes
//  TIME_W       16   song_time / note_time width, 10 ms ticks
//  TIMEOUT      100  max |error| in ticks for a match; past note expires beyond this
//  PERFECT_WIN  5    |error| <= this -> grade PERFECT
//  GOOD_WIN     15   |error| <= this -> grade GOOD, else OK
// PORTS
//  clk             in   1              system clock
//  rst_n           in   1              async active-low reset
//  clear           in   1              sync flush of all lane state (song restart)
//  song_time       in   TIME_W         current song time, monotonic except across clear
//  note_edge       in   LANES          1-cycle press pulse per lane
//  note_time       in   LANES*TIME_W   lane i at [i*TIME_W +: TIME_W]; next note from FIFO i
//  note_available  in   LANES          FIFO i has note_time valid
//  note_request    out  LANES          lane i wants its next note
//  match_valid     out  LANES          1-cycle pulse: press matched
//  match_time      out  LANES*TIME_W   matched note time, valid with match_valid
//  match_grade     out  LANES*2        2'b11 PERFECT, 2'b10 GOOD, 2'b01 OK
//  match_late      out  LANES          1: press after note (past slot); 0: early
//  miss_pulse      out  LANES          1-cycle pulse: a note left the window unmatched
//  stray_pulse     out  LANES          1-cycle pulse: press with no note in window
// BEHAVIOUR
//  Reset (rst_n=0) or clear: all outputs 0; per lane past_v=fut_v=0, past_t=fut_t=0.
//  Lanes are fully independent; all per-lane state and outputs are registered.
//  Fetch: note_request[i] is 1 while fut_v=0. When note_request[i] && note_available[i]:
//   fut_t<=note_time[i], fut_v<=1, request drops next cycle. A note is consumed once per handshake.
//  Shift: fut_v && song_time > fut_t -> past_t<=fut_t, past_v<=1, fut_v<=0.
//   If past_v was still 1, the old past note is lost: miss_pulse 1 cycle.
//  Expire: past_v && song_time > past_t+TIMEOUT (TIME_W+1-bit sum, no wrap) -> past_v<=0, miss_pulse.
//  Press (note_edge[i]=1): uses registers as of that cycle (before shift, expire, fetch).
//   dp = song_time-past_t, df = fut_t-song_time (both non-negative by construction).
//   Candidate = past if past_v && (!fut_v || dp<=df), else future if fut_v. Ties go to past.
//   If a candidate exists with err<=TIMEOUT: match_valid=1, match_time=slot time,
//   match_late=(past), grade from err. The slot's valid bit is cleared.
//   Otherwise stray_pulse=1 and no state changes.
//  Latency: match/stray/miss outputs 1 cycle after the causing edge. All pulses are exactly 1 cycle.
//  Same-cycle priority:
//   Press consumes a slot -> shift/expire of that slot is suppressed.
//   Future consumed and handshake in same cycle -> handshake does not complete (request was
//    already low since fut_v=1). Refetch starts next cycle.
//   Miss from shift and miss from expire in the same cycle -> one miss_pulse; report at most 1/cycle.
//   clear overrides everything, including an in-flight handshake (request drops, no note taken).
//  song_time going backwards without clear: undefined; upstream must pulse clear.
// TESTING
//  T1 lane0 fut_t=200, press at song_time=197 -> match_valid, time=200, grade 11, late=0, request reasserted.
//  T2 fut_t=100, song_time 101 -> shift; press at 112 -> match time=100, grade 10, late=1, past_v=0.
//  T3 past_t=100 unmatched, song_time reaches 201 -> one miss_pulse; press at 250 with fut_v=0 -> stray_pulse.
//  T4 past_t=100, fut_t=120, press at 110 -> tie, matches past (late=1, grade 10); fut note kept.
//  T5 all 5 lanes pressed same cycle with distinct notes -> 5 independent matches, correct slices of match_time.
//  T6 rst_n low mid-handshake and clear mid-match -> all outputs 0 next edge, no note consumed, refetch after release.

Source files
------------

// File: rtl/note_match_multilane.sv
// Per-lane note matcher: keeps a past and a future note slot per fret lane, pairs each press
// with the nearer slot, grades the timing error and reports misses and stray presses.
module note_match_multilane #(
    parameter int LANES       = 5,
    parameter int TIME_W      = 16,
    parameter int TIMEOUT     = 100,
    parameter int PERFECT_WIN = 5,
    parameter int GOOD_WIN    = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [TIME_W-1:0]       song_time,
    input  logic [LANES-1:0]        note_edge,
    input  logic [LANES*TIME_W-1:0] note_time,
    input  logic [LANES-1:0]        note_available,
    output logic [LANES-1:0]        note_request,
    output logic [LANES-1:0]        match_valid,
    output logic [LANES*TIME_W-1:0] match_time,
    output logic [LANES*2-1:0]      match_grade,
    output logic [LANES-1:0]        match_late,
    output logic [LANES-1:0]        miss_pulse,
    output logic [LANES-1:0]        stray_pulse
);

    typedef enum logic [1:0] {
        GRADE_NONE    = 2'b00,
        GRADE_OK      = 2'b01,
        GRADE_GOOD    = 2'b10,
        GRADE_PERFECT = 2'b11
    } grade_e;

    localparam logic [TIME_W-1:0] TIMEOUT_T = TIME_W'(TIMEOUT);
    localparam logic [TIME_W-1:0] PERFECT_T = TIME_W'(PERFECT_WIN);
    localparam logic [TIME_W-1:0] GOOD_T    = TIME_W'(GOOD_WIN);
    localparam logic [TIME_W:0]   TIMEOUT_X = (TIME_W+1)'(TIMEOUT);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [TIME_W-1:0] past_t, fut_t;
        logic              past_v, fut_v;

        logic              req_q, mv_q, late_q, miss_q, stray_q;
        logic [TIME_W-1:0] mt_q;
        grade_e            mg_q;

        logic [TIME_W-1:0] lane_note_t, dp, df, err;
        logic              pick_past, hit, take_past, take_fut;
        logic              expire, shift, past_keep, fetch, fut_v_nx;
        grade_e            grade;

        // NOTE: every signal written here gets a default at the top of the block, so no
        // path through the block leaves a value undriven and no latch is inferred.
        always_comb begin
            lane_note_t = note_time[i*TIME_W +: TIME_W];
            dp          = song_time - past_t;
            df          = fut_t - song_time;
            pick_past   = past_v && (!fut_v || dp <= df);
            err         = pick_past ? dp : df;
            hit         = note_edge[i] && (pick_past || fut_v) && (err <= TIMEOUT_T);
            take_past   = hit && pick_past;
            take_fut    = hit && !pick_past;

            // A slot taken by a press this cycle can neither expire nor shift.
            expire    = past_v && !take_past
                        && ({1'b0, song_time} > ({1'b0, past_t} + TIMEOUT_X));
            shift     = fut_v && !take_fut && (song_time > fut_t);
            past_keep = past_v && !take_past && !expire;

            // Request is only high while the future slot is empty, so a fetch never
            // collides with a shift or with a press taking the future note.
            fetch    = req_q && note_available[i];
            fut_v_nx = fetch || (fut_v && !take_fut && !shift);

            grade = GRADE_NONE;
            if (err <= PERFECT_T)   grade = GRADE_PERFECT;
            else if (err <= GOOD_T) grade = GRADE_GOOD;
            else                    grade = GRADE_OK;
        end

        // NOTE: state is updated with non-blocking assignments so every register samples
        // the values from before this edge, independent of statement order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                past_t  <= '0;
                fut_t   <= '0;
                past_v  <= 1'b0;
                fut_v   <= 1'b0;
                req_q   <= 1'b0;
                mv_q    <= 1'b0;
                mt_q    <= '0;
                mg_q    <= GRADE_NONE;
                late_q  <= 1'b0;
                miss_q  <= 1'b0;
                stray_q <= 1'b0;
            end else if (clear) begin
                past_t  <= '0;
                fut_t   <= '0;
                past_v  <= 1'b0;
                fut_v   <= 1'b0;
                req_q   <= 1'b0;
                mv_q    <= 1'b0;
                mt_q    <= '0;
                mg_q    <= GRADE_NONE;
                late_q  <= 1'b0;
                miss_q  <= 1'b0;
                stray_q <= 1'b0;
            end else begin
                mv_q    <= hit;
                mt_q    <= hit ? (pick_past ? past_t : fut_t) : '0;
                mg_q    <= hit ? grade : GRADE_NONE;
                late_q  <= take_past;
                stray_q <= note_edge[i] && !hit;
                // Expiry and a shift-induced loss in the same cycle report a single miss.
                miss_q  <= expire || (shift && past_keep);

                if (shift) begin
                    past_t <= fut_t;
                    past_v <= 1'b1;
                end else if (!past_keep) begin
                    past_v <= 1'b0;
                end

                if (fetch) fut_t <= lane_note_t;
                fut_v <= fut_v_nx;
                req_q <= !fut_v_nx;
            end
        end

        assign note_request[i]              = req_q;
        assign match_valid[i]               = mv_q;
        assign match_time[i*TIME_W +: TIME_W] = mt_q;
        assign match_grade[i*2 +: 2]        = mg_q;
        assign match_late[i]                = late_q;
        assign miss_pulse[i]                = miss_q;
        assign stray_pulse[i]               = stray_q;
    end

endmodule

// File: tb/tb_note_match_multilane.sv
// Directed bench for note_match_multilane: per-lane FIFO stubs, a slot-level reference model
// checked every cycle, and literal expectations for the key scenarios.
module tb_note_match_multilane;

    localparam int LANES = 5;
    localparam int TW    = 16;
    localparam int TO    = 100;

    logic                 clk = 1'b0;
    logic                 rst_n, clear;
    logic [TW-1:0]        song_time;
    logic [LANES-1:0]     note_edge, note_available;
    logic [LANES*TW-1:0]  note_time;
    logic [LANES-1:0]     note_request, match_valid, match_late, miss_pulse, stray_pulse;
    logic [LANES*TW-1:0]  match_time;
    logic [LANES*2-1:0]   match_grade;

    int checks = 0;
    int failures = 0;

    // FIFO stubs
    int fifo_mem [LANES][16];
    int rd [LANES];
    int wr [LANES];

    // Reference model: note slots and expected registered outputs
    bit m_pv [LANES];
    bit m_fv [LANES];
    int m_pt [LANES];
    int m_ft [LANES];
    logic [LANES-1:0]    e_req, e_mv, e_ml, e_miss, e_stray;
    logic [LANES*TW-1:0] e_mt;
    logic [LANES*2-1:0]  e_mg;

    note_match_multilane dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .song_time(song_time),
        .note_edge(note_edge), .note_time(note_time), .note_available(note_available),
        .note_request(note_request), .match_valid(match_valid), .match_time(match_time),
        .match_grade(match_grade), .match_late(match_late), .miss_pulse(miss_pulse),
        .stray_pulse(stray_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int lane, input int t);
        fifo_mem[lane][wr[lane]] = t;
        wr[lane]++;
    endtask

    task automatic refresh_fifo();
        for (int i = 0; i < LANES; i++) begin
            note_available[i]      = (rd[i] < wr[i]);
            note_time[i*TW +: TW]  = (rd[i] < wr[i]) ? TW'(fifo_mem[i][rd[i]]) : '0;
        end
    endtask

    function automatic logic [1:0] grade_of(input int err);
        if (err <= 5)  return 2'b11;
        if (err <= 15) return 2'b10;
        return 2'b01;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic [LANES-1:0] req_prev;
        int st;
        req_prev = e_req;
        e_mv = '0; e_mt = '0; e_mg = '0; e_ml = '0; e_miss = '0; e_stray = '0;
        if (!rst_n || clear) begin
            for (int i = 0; i < LANES; i++) begin
                m_pv[i] = 0; m_fv[i] = 0; m_pt[i] = 0; m_ft[i] = 0;
            end
            e_req = '0;
            return;
        end
        st = int'(song_time);
        for (int i = 0; i < LANES; i++) begin
            bit use_past, took_p, took_f;
            int err;
            took_p = 0; took_f = 0;
            if (note_edge[i]) begin
                use_past = m_pv[i] && (!m_fv[i] || (st - m_pt[i]) <= (m_ft[i] - st));
                err = use_past ? st - m_pt[i] : m_ft[i] - st;
                if ((use_past || m_fv[i]) && err <= TO) begin
                    e_mv[i] = 1'b1;
                    e_ml[i] = use_past;
                    e_mt[i*TW +: TW] = TW'(use_past ? m_pt[i] : m_ft[i]);
                    e_mg[i*2 +: 2]   = grade_of(err);
                    took_p = use_past;
                    took_f = !use_past;
                end else begin
                    e_stray[i] = 1'b1;
                end
            end
            if (took_p) m_pv[i] = 0;
            if (took_f) m_fv[i] = 0;
            if (m_pv[i] && st > m_pt[i] + TO) begin
                e_miss[i] = 1'b1;
                m_pv[i] = 0;
            end
            if (m_fv[i] && st > m_ft[i]) begin
                if (m_pv[i]) e_miss[i] = 1'b1;
                m_pv[i] = 1; m_pt[i] = m_ft[i]; m_fv[i] = 0;
            end
            if (req_prev[i] && rd[i] < wr[i]) begin
                m_ft[i] = fifo_mem[i][rd[i]];
                m_fv[i] = 1;
                rd[i]++;
            end
            e_req[i] = !m_fv[i];
        end
    endtask

    task automatic compare();
        check("note_request", note_request, e_req);
        check("match_valid",  match_valid,  e_mv);
        check("match_time",   match_time,   e_mt);
        check("match_grade",  match_grade,  e_mg);
        check("match_late",   match_late,   e_ml);
        check("miss_pulse",   miss_pulse,   e_miss);
        check("stray_pulse",  stray_pulse,  e_stray);
    endtask

    task automatic tick(input int st, input logic [LANES-1:0] edges);
        song_time = TW'(st);
        note_edge = edges;
        refresh_fifo();
        model_step();
        @(posedge clk);
        #1;
        compare();
        note_edge = '0;
        refresh_fifo();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(0, '0);
        clear = 1'b0;
        check("clear_req_low", note_request, '0);
    endtask

    int miss_count;

    initial begin
        rst_n = 1'b0; clear = 1'b0; song_time = '0; note_edge = '0;
        e_req = '0;
        for (int i = 0; i < LANES; i++) begin
            rd[i] = 0; wr[i] = 0;
        end
        refresh_fifo();
        tick(0, '0);
        tick(0, '0);
        check("reset_req", note_request, '0);
        check("reset_valid", match_valid, '0);
        rst_n = 1'b1;
        tick(0, '0);
        check("req_after_reset", note_request, 5'h1f);

        // T1: early press on the future note
        push(0, 200);
        tick(190, '0);
        tick(195, '0);
        tick(197, 5'h01);
        check("t1_valid", match_valid[0], 1'b1);
        check("t1_time",  match_time[15:0], 16'd200);
        check("t1_grade", match_grade[1:0], 2'b11);
        check("t1_late",  match_late[0], 1'b0);
        check("t1_req",   note_request[0], 1'b1);

        // T2: shifted note matched late
        do_clear();
        push(0, 100);
        tick(90, '0);
        tick(91, '0);
        tick(101, '0);
        tick(112, 5'h01);
        check("t2_time",  match_time[15:0], 16'd100);
        check("t2_grade", match_grade[1:0], 2'b10);
        check("t2_late",  match_late[0], 1'b1);
        tick(113, 5'h01);
        check("t2_past_cleared", stray_pulse[0], 1'b1);

        // T3: past note expires exactly once, then a stray press
        do_clear();
        push(0, 100);
        tick(90, '0);
        tick(91, '0);
        tick(101, '0);
        miss_count = 0;
        for (int t = 102; t <= 205; t++) begin
            tick(t, '0);
            if (miss_pulse[0]) miss_count++;
            if (t == 200) check("t3_no_early_miss", miss_count, 0);
        end
        check("t3_miss_count", miss_count, 1);
        tick(250, 5'h01);
        check("t3_stray", stray_pulse[0], 1'b1);

        // T4: equidistant press goes to the past note, future stays
        do_clear();
        push(0, 100);
        push(0, 120);
        tick(90, '0);
        tick(91, '0);
        tick(101, '0);
        tick(102, '0);
        tick(110, 5'h01);
        check("t4_time",  match_time[15:0], 16'd100);
        check("t4_late",  match_late[0], 1'b1);
        check("t4_grade", match_grade[1:0], 2'b10);
        tick(118, 5'h01);
        check("t4_fut_kept", match_time[15:0], 16'd120);
        check("t4_fut_grade", match_grade[1:0], 2'b11);

        // T5: all lanes pressed together
        do_clear();
        for (int i = 0; i < LANES; i++) push(i, 300 + 10*i);
        tick(290, '0);
        tick(291, '0);
        tick(300, 5'h1f);
        check("t5_valid", match_valid, 5'h1f);
        check("t5_time",  match_time, {16'd340, 16'd330, 16'd320, 16'd310, 16'd300});
        check("t5_grade", match_grade, 10'b01_01_01_10_11);
        check("t5_late",  match_late, 5'h00);

        // T6: reset during a handshake, clear during a press
        do_clear();
        tick(400, '0);
        push(0, 500);
        rst_n = 1'b0;
        tick(400, '0);
        check("t6_reset_req", note_request, '0);
        rst_n = 1'b1;
        tick(401, '0);
        tick(402, '0);
        push(0, 510);
        tick(495, 5'h01);
        check("t6_match_500", match_time[15:0], 16'd500);
        clear = 1'b1;
        tick(496, 5'h01);
        clear = 1'b0;
        check("t6_clear_stray", stray_pulse[0], 1'b0);
        tick(500, '0);
        tick(501, '0);
        push(0, 520);
        clear = 1'b1;
        tick(508, 5'h01);
        clear = 1'b0;
        check("t6_clear_match", match_valid[0], 1'b0);
        tick(510, '0);
        tick(511, '0);
        tick(515, 5'h01);
        check("t6_refetch", match_time[15:0], 16'd520);
        tick(516, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
